// File: rtl/mem_bus_arbiter.sv
// Shares one SRAM-like bus port between instruction fetch and data access,
// sequencing address and data phases and returning a one-cycle ok pulse to the owner.
module mem_bus_arbiter #(
   parameter bit PRIO_DATA = 1'b1,
   parameter bit KSEG_MAP  = 1'b1
) (
   input  logic        clk,
   input  logic        resetn,
   input  logic        inst_req,
   input  logic [31:0] inst_addr,
   input  logic        inst_flush,
   output logic [31:0] inst_rdata,
   output logic        inst_ok,
   input  logic        data_req,
   input  logic        data_wr,
   input  logic [3:0]  data_sel,
   input  logic [1:0]  data_size,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic [31:0] data_rdata,
   output logic        data_ok,
   output logic        bus_req,
   output logic        bus_wr,
   output logic [1:0]  bus_size,
   output logic [3:0]  bus_sel,
   output logic [31:0] bus_addr,
   output logic [31:0] bus_wdata,
   input  logic        bus_addr_ok,
   input  logic        bus_data_ok,
   input  logic [31:0] bus_rdata,
   output logic [1:0]  dbg_state
);

   // Handshake: a requester holds req and its fields until its ok pulse; the bus
   // accepts the address phase on bus_req && bus_addr_ok and ends the data phase
   // on bus_data_ok.
   typedef enum logic [1:0] {S_IDLE = 2'd0, S_ADDR = 2'd1, S_DATA = 2'd2} state_t;

   state_t      state, state_next;
   logic        owner_data, owner_data_next;
   logic        discard, discard_next;
   logic        done;
   logic        bus_req_n, bus_wr_n;
   logic [1:0]  bus_size_n;
   logic [3:0]  bus_sel_n;
   logic [31:0] bus_addr_n, bus_wdata_n;
   logic [31:0] inst_rdata_n, data_rdata_n;
   logic        inst_ok_n, data_ok_n;
   logic        inst_pend, data_pend, grant_data, grant_inst, suppress;

   function automatic logic [31:0] map_addr(input logic [31:0] a);
      if (KSEG_MAP && a[31:30] == 2'b10) return {3'b000, a[28:0]};
      return a;
   endfunction

   // A requester whose ok is pulsing this cycle is still holding a stale req.
   assign inst_pend  = inst_req && !inst_ok;
   assign data_pend  = data_req && !data_ok;
   assign grant_data = data_pend && (PRIO_DATA || !inst_pend);
   assign grant_inst = inst_pend && !grant_data;
   assign suppress   = data_wr && (data_sel == 4'b0000);
   assign dbg_state  = state;

   always_comb begin
      state_next      = state;
      owner_data_next = owner_data;
      discard_next    = discard;
      bus_req_n       = bus_req;
      bus_wr_n        = bus_wr;
      bus_size_n      = bus_size;
      bus_sel_n       = bus_sel;
      bus_addr_n      = bus_addr;
      bus_wdata_n     = bus_wdata;
      inst_rdata_n    = inst_rdata;
      data_rdata_n    = data_rdata;
      inst_ok_n       = 1'b0;
      data_ok_n       = 1'b0;
      done            = 1'b0;
      case (state)
         S_IDLE: begin
            if (grant_data) begin
               if (suppress) begin
                  data_ok_n = 1'b1;
               end else begin
                  owner_data_next = 1'b1;
                  bus_req_n       = 1'b1;
                  bus_wr_n        = data_wr;
                  bus_size_n      = data_size;
                  bus_sel_n       = data_sel;
                  bus_addr_n      = map_addr(data_addr);
                  bus_wdata_n     = data_wdata;
                  state_next      = S_ADDR;
               end
            end else if (grant_inst) begin
               owner_data_next = 1'b0;
               discard_next    = 1'b0;
               bus_req_n       = 1'b1;
               bus_wr_n        = 1'b0;
               bus_size_n      = 2'b10;
               bus_sel_n       = 4'b0000;
               bus_addr_n      = map_addr(inst_addr);
               bus_wdata_n     = 32'd0;
               state_next      = S_ADDR;
            end
         end
         S_ADDR: begin
            if (bus_addr_ok) begin
               bus_req_n = 1'b0;
               if (bus_data_ok) done = 1'b1;
               else state_next = S_DATA;
            end
         end
         S_DATA: begin
            if (bus_data_ok) done = 1'b1;
         end
         default: state_next = S_IDLE;
      endcase

      if (state != S_IDLE && !owner_data && inst_flush) discard_next = 1'b1;

      // A flush arriving in the completion cycle itself still discards the fetch.
      if (done) begin
         state_next   = S_IDLE;
         discard_next = 1'b0;
         if (owner_data) begin
            data_rdata_n = bus_rdata;
            data_ok_n    = 1'b1;
         end else if (!(discard || inst_flush)) begin
            inst_rdata_n = bus_rdata;
            inst_ok_n    = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state      <= S_IDLE;
         owner_data <= 1'b0;
         discard    <= 1'b0;
         bus_req    <= 1'b0;
         bus_wr     <= 1'b0;
         bus_size   <= 2'b00;
         bus_sel    <= 4'b0000;
         bus_addr   <= 32'd0;
         bus_wdata  <= 32'd0;
         inst_rdata <= 32'd0;
         data_rdata <= 32'd0;
         inst_ok    <= 1'b0;
         data_ok    <= 1'b0;
      end else begin
         state      <= state_next;
         owner_data <= owner_data_next;
         discard    <= discard_next;
         bus_req    <= bus_req_n;
         bus_wr     <= bus_wr_n;
         bus_size   <= bus_size_n;
         bus_sel    <= bus_sel_n;
         bus_addr   <= bus_addr_n;
         bus_wdata  <= bus_wdata_n;
         inst_rdata <= inst_rdata_n;
         data_rdata <= data_rdata_n;
         inst_ok    <= inst_ok_n;
         data_ok    <= data_ok_n;
      end
   end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter: table of single transactions plus
// hand-written sequences for arbitration, suppressed store, flush and reset.
module tb_mem_bus_arbiter;

   logic        clk = 1'b0;
   logic        resetn;
   logic        inst_req, inst_flush, inst_ok;
   logic [31:0] inst_addr, inst_rdata;
   logic        data_req, data_wr, data_ok;
   logic [3:0]  data_sel;
   logic [1:0]  data_size;
   logic [31:0] data_addr, data_wdata, data_rdata;
   logic        bus_req, bus_wr, bus_addr_ok, bus_data_ok;
   logic [1:0]  bus_size;
   logic [3:0]  bus_sel;
   logic [31:0] bus_addr, bus_wdata, bus_rdata;
   logic [1:0]  dbg_state;

   int errors = 0;
   int checks = 0;
   logic [31:0] exp_inst_rdata = 32'd0;

   always #5 clk = ~clk;

   mem_bus_arbiter #(.PRIO_DATA(1'b1), .KSEG_MAP(1'b1)) dut (
      .clk(clk), .resetn(resetn),
      .inst_req(inst_req), .inst_addr(inst_addr), .inst_flush(inst_flush),
      .inst_rdata(inst_rdata), .inst_ok(inst_ok),
      .data_req(data_req), .data_wr(data_wr), .data_sel(data_sel),
      .data_size(data_size), .data_addr(data_addr), .data_wdata(data_wdata),
      .data_rdata(data_rdata), .data_ok(data_ok),
      .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_sel(bus_sel),
      .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok),
      .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata), .dbg_state(dbg_state)
   );

   typedef struct {
      bit          is_data;
      bit          wr;
      logic [3:0]  sel;
      logic [1:0]  size;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic [31:0] exp_addr;
      int          wait_cyc;
   } vec_t;

   vec_t vecs[6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Drives one transaction and plays a slave that accepts the address after wait_cyc cycles.
   task automatic run_vec(input vec_t v);
      logic        got_ok, other_ok;
      logic [31:0] got_rdata;
      if (v.is_data) begin
         data_req = 1'b1; data_wr = v.wr; data_sel = v.sel; data_size = v.size;
         data_addr = v.addr; data_wdata = v.wdata;
      end else begin
         inst_req = 1'b1; inst_addr = v.addr;
      end
      step();
      chk("grant_bus_req", 32'(bus_req), 32'd1);
      chk("grant_bus_addr", bus_addr, v.exp_addr);
      chk("grant_bus_wr", 32'(bus_wr), v.is_data ? 32'(v.wr) : 32'd0);
      chk("grant_bus_size", 32'(bus_size), v.is_data ? 32'(v.size) : 32'd2);
      chk("grant_bus_sel", 32'(bus_sel), v.is_data ? 32'(v.sel) : 32'd0);
      if (v.is_data && v.wr) chk("grant_bus_wdata", bus_wdata, v.wdata);
      for (int i = 0; i < v.wait_cyc; i++) begin
         step();
         chk("hold_bus_req", 32'(bus_req), 32'd1);
         chk("hold_bus_addr", bus_addr, v.exp_addr);
      end
      bus_addr_ok = 1'b1;
      step();
      bus_addr_ok = 1'b0;
      chk("data_phase_bus_req", 32'(bus_req), 32'd0);
      chk("data_phase_dbg_state", 32'(dbg_state), 32'd2);
      bus_data_ok = 1'b1;
      bus_rdata   = v.rdata;
      step();
      bus_data_ok = 1'b0;
      bus_rdata   = 32'd0;
      got_ok    = v.is_data ? data_ok : inst_ok;
      other_ok  = v.is_data ? inst_ok : data_ok;
      got_rdata = v.is_data ? data_rdata : inst_rdata;
      chk("ok_pulse", 32'(got_ok), 32'd1);
      chk("other_ok_quiet", 32'(other_ok), 32'd0);
      chk("rdata", got_rdata, v.rdata);
      if (!v.is_data) exp_inst_rdata = v.rdata;
      step();
      chk("ok_single_pulse", 32'(got_ok ? (v.is_data ? data_ok : inst_ok) : 1'b1), 32'd0);
      chk("no_reissue", 32'(bus_req), 32'd0);
      inst_req = 1'b0;
      data_req = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      resetn = 1'b0;
      inst_req = 1'b0; inst_addr = 32'd0; inst_flush = 1'b0;
      data_req = 1'b0; data_wr = 1'b0; data_sel = 4'd0; data_size = 2'd0;
      data_addr = 32'd0; data_wdata = 32'd0;
      bus_addr_ok = 1'b0; bus_data_ok = 1'b0; bus_rdata = 32'd0;

      vecs[0] = '{1'b0, 1'b0, 4'b0000, 2'b10, 32'hBFC0_0000, 32'd0, 32'h3C1D_A000, 32'h1FC0_0000, 0};
      vecs[1] = '{1'b1, 1'b0, 4'b0000, 2'b10, 32'h8000_1000, 32'd0, 32'h1234_5678, 32'h0000_1000, 0};
      vecs[2] = '{1'b1, 1'b1, 4'b1000, 2'b00, 32'h0000_0003, 32'h5A5A_5A5A, 32'h0BAD_0BAD, 32'h0000_0003, 4};
      vecs[3] = '{1'b0, 1'b0, 4'b0000, 2'b10, 32'h0040_0000, 32'd0, 32'h2408_0001, 32'h0040_0000, 2};
      vecs[4] = '{1'b1, 1'b1, 4'b1100, 2'b01, 32'hA000_2002, 32'hBEEF_BEEF, 32'h7777_0000, 32'h0000_2002, 1};
      vecs[5] = '{1'b1, 1'b0, 4'b0000, 2'b10, 32'hC000_0000, 32'd0, 32'hFEDC_BA98, 32'hC000_0000, 0};

      repeat (2) step();
      chk("reset_bus_req", 32'(bus_req), 32'd0);
      chk("reset_bus_addr", bus_addr, 32'd0);
      chk("reset_inst_ok", 32'(inst_ok), 32'd0);
      chk("reset_data_ok", 32'(data_ok), 32'd0);
      chk("reset_inst_rdata", inst_rdata, 32'd0);
      chk("reset_data_rdata", data_rdata, 32'd0);
      chk("reset_dbg_state", 32'(dbg_state), 32'd0);
      resetn = 1'b1;
      step();

      for (int i = 0; i < 6; i++) run_vec(vecs[i]);

      // Simultaneous requests: data first, inst granted in the data_ok cycle.
      inst_req = 1'b1; inst_addr = 32'h9FC0_0100;
      data_req = 1'b1; data_wr = 1'b0; data_sel = 4'b0000; data_size = 2'b10;
      data_addr = 32'h8000_1000;
      step();
      chk("prio_bus_addr", bus_addr, 32'h0000_1000);
      chk("prio_bus_wr", 32'(bus_wr), 32'd0);
      bus_addr_ok = 1'b1;
      step();
      bus_addr_ok = 1'b0;
      bus_data_ok = 1'b1; bus_rdata = 32'hCAFE_F00D;
      step();
      bus_data_ok = 1'b0; bus_rdata = 32'd0;
      chk("prio_data_ok", 32'(data_ok), 32'd1);
      chk("prio_data_rdata", data_rdata, 32'hCAFE_F00D);
      chk("prio_inst_ok_quiet", 32'(inst_ok), 32'd0);
      step();
      data_req = 1'b0;
      chk("prio_data_ok_single", 32'(data_ok), 32'd0);
      chk("prio_inst_bus_req", 32'(bus_req), 32'd1);
      chk("prio_inst_bus_addr", bus_addr, 32'h1FC0_0100);
      bus_addr_ok = 1'b1;
      step();
      bus_addr_ok = 1'b0;
      bus_data_ok = 1'b1; bus_rdata = 32'h1111_2222;
      step();
      bus_data_ok = 1'b0; bus_rdata = 32'd0;
      chk("prio_inst_ok", 32'(inst_ok), 32'd1);
      chk("prio_inst_rdata", inst_rdata, 32'h1111_2222);
      exp_inst_rdata = 32'h1111_2222;
      step();
      inst_req = 1'b0;
      chk("prio_inst_ok_single", 32'(inst_ok), 32'd0);
      chk("prio_no_dup", 32'(bus_req), 32'd0);
      step();

      // Suppressed store: no bus activity, one data_ok.
      data_req = 1'b1; data_wr = 1'b1; data_sel = 4'b0000; data_size = 2'b10;
      data_addr = 32'h0000_0001; data_wdata = 32'h1234_1234;
      step();
      chk("supp_data_ok", 32'(data_ok), 32'd1);
      chk("supp_bus_req", 32'(bus_req), 32'd0);
      chk("supp_dbg_state", 32'(dbg_state), 32'd0);
      step();
      data_req = 1'b0;
      chk("supp_data_ok_single", 32'(data_ok), 32'd0);
      chk("supp_bus_req_after", 32'(bus_req), 32'd0);
      step();

      // Flush during inst data phase: bus completes, result discarded.
      inst_req = 1'b1; inst_addr = 32'h0040_0010;
      step();
      chk("flush_bus_req", 32'(bus_req), 32'd1);
      bus_addr_ok = 1'b1;
      step();
      bus_addr_ok = 1'b0;
      chk("flush_dbg_data", 32'(dbg_state), 32'd2);
      inst_req = 1'b0; inst_flush = 1'b1;
      step();
      inst_flush = 1'b0;
      bus_data_ok = 1'b1; bus_rdata = 32'hDEAD_BEEF;
      step();
      bus_data_ok = 1'b0; bus_rdata = 32'd0;
      chk("flush_no_inst_ok", 32'(inst_ok), 32'd0);
      chk("flush_rdata_kept", inst_rdata, exp_inst_rdata);
      chk("flush_dbg_idle", 32'(dbg_state), 32'd0);
      step();
      chk("flush_no_late_ok", 32'(inst_ok), 32'd0);
      run_vec(vecs[0]);
      step();

      // Reset in the address phase abandons the transaction.
      inst_req = 1'b1; inst_addr = 32'hBFC0_0000;
      step();
      chk("rst_pre_bus_req", 32'(bus_req), 32'd1);
      resetn = 1'b0;
      #1;
      chk("rst_bus_req", 32'(bus_req), 32'd0);
      chk("rst_bus_addr", bus_addr, 32'd0);
      chk("rst_inst_rdata", inst_rdata, 32'd0);
      chk("rst_dbg_state", 32'(dbg_state), 32'd0);
      inst_req = 1'b0;
      step();
      resetn = 1'b1;
      repeat (2) begin
         step();
         chk("rst_after_inst_ok", 32'(inst_ok), 32'd0);
         chk("rst_after_bus_req", 32'(bus_req), 32'd0);
         chk("rst_after_dbg", 32'(dbg_state), 32'd0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
